// File: rtl/iter_divider_pkg.sv
// iter_divider_pkg: constants shared by the iterative divider.
//   - ALU op-select codes consumed from alu_control_unit (5 bits)
//   - FSM state encoding of the divider
//   - is_div_op(): true for the four divide/remainder selects
package iter_divider_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_DIV  = 5'd16;
  localparam logic [4:0] ALU_DIVU = 5'd17;
  localparam logic [4:0] ALU_REM  = 5'd18;
  localparam logic [4:0] ALU_REMU = 5'd19;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_DIVIDE = 2'd1,
    DIV_FINISH = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input logic [4:0] sel);
    return (sel == ALU_DIV) || (sel == ALU_DIVU) ||
           (sel == ALU_REM) || (sel == ALU_REMU);
  endfunction

endpackage

// File: rtl/iter_divider_div_step.sv
// div_step: one combinational radix-2 restoring division step.
// Ports:
//   rem_in  [XLEN]  partial remainder
//   q_in    [XLEN]  dividend/quotient shift register (MSB shifts into rem)
//   divisor [XLEN]  unsigned divisor magnitude
//   rem_out [XLEN]  updated partial remainder
//   q_out   [XLEN]  shifted quotient with the new bit in [0]
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] q_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] q_out
);

  // One extra bit so a remainder with its top bit set still compares correctly.
  logic [XLEN:0] shifted;
  logic          ge;

  always_comb begin
    shifted = {rem_in, q_in[XLEN-1]};
    ge      = shifted >= {1'b0, divisor};
    rem_out = ge ? XLEN'(shifted - {1'b0, divisor}) : shifted[XLEN-1:0];
    q_out   = {q_in[XLEN-2:0], ge};
  end

endmodule

// File: rtl/iter_divider.sv
// iter_divider: multi-cycle signed/unsigned divide and remainder.
// Runs XLEN restoring steps, then presents a registered result with a
// one-cycle done pulse. busy is high whenever the FSM is not idle.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start, ALUsel   request and op select (DIV/DIVU/REM/REMU accepted)
//   op_a, op_b      dividend, divisor
//   kill            abort back to idle, no done, result untouched
//   busy, done      status; result valid while done is high
//   result          quotient or remainder, held until the next op finishes
// Optional: define DIV_EARLY_OUT_EN to finish in one cycle when
// |op_b| > |op_a| (quotient 0, remainder |op_a|).
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      ALUsel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] q_q, rem_q, div_q, result_q;
  logic            is_rem_q, signed_q, sign_q_q, sign_r_q, done_q;

  // Accept-time decode
  logic            sgn_d, is_rem_d, sign_q_d, sign_r_d;
  logic [XLEN-1:0] mag_a_d, mag_b_d;
  logic            b_zero_d, ovf_d, early_d;

  // Step outputs
  logic [XLEN-1:0] step_rem, step_q;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .q_in    (q_q),
    .divisor (div_q),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  always_comb begin
    sgn_d    = (ALUsel == ALU_DIV) || (ALUsel == ALU_REM);
    is_rem_d = (ALUsel == ALU_REM) || (ALUsel == ALU_REMU);
    sign_q_d = op_a[XLEN-1] ^ op_b[XLEN-1];
    sign_r_d = op_a[XLEN-1];
    mag_a_d  = (sgn_d && op_a[XLEN-1]) ? -op_a : op_a;
    mag_b_d  = (sgn_d && op_b[XLEN-1]) ? -op_b : op_b;
    b_zero_d = (op_b == '0);
    ovf_d    = sgn_d && (op_a == MIN_INT) && (op_b == '1);
`ifdef DIV_EARLY_OUT_EN
    early_d  = !b_zero_d && (mag_b_d > mag_a_d);
`else
    early_d  = 1'b0;
`endif
  end

  // Apply op selection and sign fix-up to unsigned quotient/remainder.
  function automatic logic [XLEN-1:0] fix_res(
    input logic is_rem, input logic sgn, input logic sq, input logic sr,
    input logic [XLEN-1:0] q, input logic [XLEN-1:0] r);
    if (is_rem) return (sgn && sr) ? -r : r;
    return (sgn && sq) ? -q : q;
  endfunction

  // The result and done pulse are registered on the edge entering FINISH,
  // so both are visible for exactly the FINISH cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      q_q      <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      result_q <= '0;
      is_rem_q <= 1'b0;
      signed_q <= 1'b0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        DIV_IDLE: begin
          if (start && !kill && is_div_op(ALUsel)) begin
            is_rem_q <= is_rem_d;
            signed_q <= sgn_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            div_q    <= mag_b_d;
            if (b_zero_d) begin
              result_q <= is_rem_d ? op_a : '1;
              done_q   <= 1'b1;
              state_q  <= DIV_FINISH;
            end else if (ovf_d) begin
              result_q <= is_rem_d ? '0 : MIN_INT;
              done_q   <= 1'b1;
              state_q  <= DIV_FINISH;
            end else if (early_d) begin
              result_q <= fix_res(is_rem_d, sgn_d, sign_q_d, sign_r_d, '0, mag_a_d);
              done_q   <= 1'b1;
              state_q  <= DIV_FINISH;
            end else begin
              q_q     <= mag_a_d;
              rem_q   <= '0;
              cnt_q   <= CW'(XLEN);
              state_q <= DIV_DIVIDE;
            end
          end
        end
        DIV_DIVIDE: begin
          if (kill) begin
            state_q <= DIV_IDLE;
          end else begin
            q_q   <= step_q;
            rem_q <= step_rem;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              result_q <= fix_res(is_rem_q, signed_q, sign_q_q, sign_r_q, step_q, step_rem);
              done_q   <= 1'b1;
              state_q  <= DIV_FINISH;
            end
          end
        end
        DIV_FINISH: state_q <= DIV_IDLE;
        default:    state_q <= DIV_IDLE;
      endcase
    end
  end

  assign busy   = (state_q != DIV_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_iter_divider.sv
module tb_iter_divider;
  import iter_divider_pkg::*;

  localparam int XLEN = 32;
  localparam logic [31:0] MINI = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            start, kill;
  logic [4:0]      ALUsel;
  logic [XLEN-1:0] op_a, op_b;
  logic            busy, done;
  logic [XLEN-1:0] result;

  int nchk = 0;
  int nerr = 0;

  iter_divider #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUsel(ALUsel),
    .op_a(op_a), .op_b(op_b), .kill(kill),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain SV arithmetic plus the two architectural corner cases.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn, isrem;
    sgn   = (op == ALU_DIV) || (op == ALU_REM);
    isrem = (op == ALU_REM) || (op == ALU_REMU);
    if (b == 0) return isrem ? a : 32'hFFFF_FFFF;
    if (sgn && a == MINI && b == 32'hFFFF_FFFF) return isrem ? 32'd0 : MINI;
    if (sgn) return isrem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return isrem ? a % b : a / b;
  endfunction

  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    logic [31:0] ma, mb;
    sgn = (op == ALU_DIV) || (op == ALU_REM);
    if (b == 0) return 1;
    if (sgn && a == MINI && b == 32'hFFFF_FFFF) return 1;
    ma = (sgn && a[31]) ? 32'(-a) : a;
    mb = (sgn && b[31]) ? 32'(-b) : b;
`ifdef DIV_EARLY_OUT_EN
    if (mb > ma) return 1;
`else
    if (mb > ma) return XLEN + 1;
`endif
    return XLEN + 1;
  endfunction

  // Drive one request (phase: just after a rising edge), then wait for done.
  // Operands are scrambled after accept to show they are not re-sampled.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    logic busy_ok;
    logic [31:0] e;
    e = model(op, a, b);
    start = 1'b1; ALUsel = op; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    cyc = 1; busy_ok = 1'b1;
    while (!done && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    if (!busy) busy_ok = 1'b0;
    chk({tag, ".lat"}, 64'(cyc), 64'(exp_lat(op, a, b)));
    chk({tag, ".res"}, 64'(result), 64'(e));
    chk({tag, ".busy"}, 64'(busy_ok), 64'd1);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, {62'd0, done, busy}, 64'd0);
    chk({tag, ".hold"}, 64'(result), 64'(e));
  endtask

  initial begin
    logic [31:0] held;
    logic        saw;
    logic [4:0]  ops [4];
    ops[0] = ALU_DIV; ops[1] = ALU_DIVU; ops[2] = ALU_REM; ops[3] = ALU_REMU;

    rst = 1'b1; start = 1'b0; kill = 1'b0; ALUsel = ALU_ADD; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {61'd0, busy, done, |result}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("divu100_7", ALU_DIVU, 32'd100, 32'd7);
    run_op("remu100_7", ALU_REMU, 32'd100, 32'd7);
    run_op("div-20_3",  ALU_DIV,  32'hFFFF_FFEC, 32'd3);
    run_op("rem-20_3",  ALU_REM,  32'hFFFF_FFEC, 32'd3);
    run_op("rem20_-3",  ALU_REM,  32'd20, 32'hFFFF_FFFD);
    run_op("div5_0",    ALU_DIV,  32'd5, 32'd0);
    run_op("rem5_0",    ALU_REM,  32'd5, 32'd0);
    run_op("div_ovf",   ALU_DIV,  MINI, 32'hFFFF_FFFF);
    run_op("rem_ovf",   ALU_REM,  MINI, 32'hFFFF_FFFF);
    run_op("divu3_10",  ALU_DIVU, 32'd3, 32'd10);
    run_op("divu_max",  ALU_DIVU, 32'hFFFF_FFFF, 32'd1);
    run_op("remu_big",  ALU_REMU, 32'hFFFF_FFFF, 32'h8000_0001);

    // Non-divide select is ignored.
    held = result;
    start = 1'b1; ALUsel = ALU_ADD; op_a = 32'd9; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    saw = 1'b0;
    repeat (5) begin
      if (busy || done) saw = 1'b1;
      @(posedge clk); #1;
    end
    chk("add_ignored", {63'd0, saw}, 64'd0);
    chk("add_hold", 64'(result), 64'(held));

    // kill wins over start in IDLE.
    start = 1'b1; kill = 1'b1; ALUsel = ALU_DIVU; op_a = 32'd50; op_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    chk("kill_prio", {62'd0, busy, done}, 64'd0);

    // Second start during DIVIDE is ignored.
    begin
      int cyc;
      start = 1'b1; ALUsel = ALU_DIVU; op_a = 32'd1000; op_b = 32'd10;
      @(posedge clk); #1;
      start = 1'b0; cyc = 1;
      repeat (4) begin @(posedge clk); #1; cyc++; end
      start = 1'b1; ALUsel = ALU_REMU; op_a = 32'd77; op_b = 32'd0;
      @(posedge clk); #1;
      start = 1'b0; cyc++;
      while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
      chk("restart_lat", 64'(cyc), 64'd33);
      chk("restart_res", 64'(result), 64'd100);
      @(posedge clk); #1;
    end

    // kill at cycle 10: back to IDLE, no done, result unchanged.
    begin
      int cyc;
      held = result;
      start = 1'b1; ALUsel = ALU_DIVU; op_a = 32'd999; op_b = 32'd4;
      @(posedge clk); #1;
      start = 1'b0; cyc = 1;
      while (cyc < 10) begin @(posedge clk); #1; cyc++; end
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      chk("kill_idle", {63'd0, busy}, 64'd0);
      saw = 1'b0;
      repeat (40) begin
        if (done || busy) saw = 1'b1;
        @(posedge clk); #1;
      end
      chk("kill_nodone", {63'd0, saw}, 64'd0);
      chk("kill_hold", 64'(result), 64'(held));
      run_op("after_kill", ALU_DIVU, 32'd999, 32'd4);
    end

    // Randomized ops.
    for (int i = 0; i < 150; i++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      op = ops[$urandom_range(0, 3)];
      a  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 15);
        3: b = 32'($urandom_range(0, 15)) - 32'd8;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) a = MINI;
      if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 100);
      run_op($sformatf("rnd%0d", i), op, a, b);
    end

    // Asynchronous reset mid-DIVIDE.
    run_op("pre_rst", ALU_DIVU, 32'd12345, 32'd1);
    start = 1'b1; ALUsel = ALU_DIVU; op_a = 32'd500; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {30'd0, busy, done, result}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("post_rst", ALU_REMU, 32'd100, 32'd7);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
